mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have exactly one clock, port clock (input, 1), and reset SHALL be asynchronous and active-low, port reset (input, 1).
REQ-002 start  input  1  one-cycle request pulse, sampled on rising clock.
REQ-003 op  input  1  operation select: 0 = MULT (signed), 1 = DIV (signed).
REQ-004 a  input  32  operand A (multiplicand / dividend), taken from register A output.
REQ-005 b  input  32  operand B (multiplier / divisor), taken from register B output.
REQ-006 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-007 done  output  1  single-cycle completion pulse.
REQ-008 div_zero  output  1  high together with done when a DIV had b = 0.
REQ-009 hi  output  32  HI result register, consumed by the MEMtoReg mux (mfhi).
REQ-010 lo  output  32  LO result register, consumed by the MEMtoReg mux (mflo).

Function
REQ-011 The state machine SHALL have the states IDLE, MULT, DIV, FIX and DONE.
REQ-012 IDLE: start=1 SHALL latch a, b and op, and SHALL compute and hold abs(a), abs(b) and the result signs.
REQ-013 IDLE transitions: op=0 -> MULT; op=1 with b!=0 -> DIV; op=1 with b=0 -> DONE with div_zero set.
REQ-014 Operand absolute values SHALL be 33-bit unsigned, so that 0x80000000 maps to +2^31 without overflow.
REQ-015 MULT SHALL run unsigned shift-add, one partial product per cycle, 32 cycles counted by a 6-bit counter, producing a 64-bit magnitude.
REQ-016 DIV SHALL run restoring division, one quotient bit per cycle, 32 cycles, producing a 32-bit quotient and remainder magnitude.
REQ-017 FIX, MULT: if sign(a) != sign(b), the 64-bit product SHALL be negated; hi = [63:32], lo = [31:0].
REQ-018 FIX, DIV: lo = quotient, negated if sign(a) != sign(b); hi = remainder, negated if a is negative (truncation toward zero).
REQ-019 FIX SHALL write hi/lo and then go to DONE; DONE SHALL assert done for one cycle and then return to IDLE.
REQ-020 Latency: done SHALL be high in the 34th cycle after the start-sampling edge for MULT/DIV, and in the 1st cycle after it for divide-by-zero.
REQ-021 Divide-by-zero SHALL leave hi/lo unchanged.
REQ-022 hi/lo SHALL hold their values until the next FIX write; they SHALL be stable and valid while done is high.
REQ-023 start SHALL be ignored while busy is high or the state is DONE; no queueing.
REQ-024 a/b changes after acceptance SHALL NOT affect the result in progress.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0, with no flag.
REQ-026 The block SHALL NOT write the register file or the PC; it only produces hi/lo/done.

Reset
REQ-027 reset low SHALL immediately force IDLE; busy, done and div_zero = 0; hi and lo = 0x00000000; counter and internal accumulators = 0.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset is released SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the op encodings (OP_MULT = 0, OP_DIV = 1), the state encoding, and the iteration count constant (32).
REQ-030 One combinational sub-module, md_abs (32-bit signed in -> 33-bit magnitude plus sign bit out), SHALL be instantiated twice; all other logic SHALL be in mult_div_unit.

Verification
REQ-031 MULT a=6, b=7 -> done at cycle 34; hi=0x00000000, lo=0x0000002A; busy high for cycles 1-33.
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; a second case a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIV with b=0 after a prior result hi=1, lo=2 -> done and div_zero in cycle 1; hi=1 and lo=2 unchanged.
REQ-035 start re-pulsed at cycle 10 with different operands -> ignored; the original result is delivered at cycle 34.
REQ-036 reset low at cycle 15 of a MULT -> no done pulse; hi=lo=0 and busy=0; a new MULT 2*3 after release -> lo=6 at cycle 34.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM state encoding and iteration count.
package mult_div_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITERATIONS = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_abs.sv
// md_abs: signed 32-bit value to 33-bit magnitude plus sign.
// Ports: value (in, 32), mag (out, 33), neg (out, 1).
module md_abs (
    input  logic [31:0] value,
    output logic [32:0] mag,
    output logic        neg
);

    // 33 bits so that 0x80000000 becomes +2^31 without overflow
    assign neg = value[31];
    assign mag = neg ? ({1'b0, ~value} + 33'd1) : {1'b0, value};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / divide unit producing HI/LO.
// Ports: clock, reset (async low), start, op, a, b -> busy, done, div_zero, hi, lo.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t state, state_nxt;

    logic [5:0]  cnt;
    logic        op_q;
    logic        neg_res;
    logic        neg_a;
    logic        dz_q;

    logic [63:0] prod;
    logic [63:0] mcand;
    logic [32:0] mplier;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [32:0] dvsr;

    logic [32:0] a_mag, b_mag;
    logic        a_neg, b_neg;

    md_abs u_abs_a (.value(a), .mag(a_mag), .neg(a_neg));
    md_abs u_abs_b (.value(b), .mag(b_mag), .neg(b_neg));

    logic        last_iter;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_sub;
    logic [63:0] prod_fix;

    assign last_iter = (cnt == 6'(ITERATIONS - 1));

    // Restoring step: shift next dividend bit in, subtract if it fits.
    // A fitting difference is below the divisor, so 32 bits suffice.
    assign rem_sh  = {rem, quo[31]};
    assign fits    = (rem_sh >= dvsr);
    assign rem_sub = 32'(rem_sh - dvsr);

    assign prod_fix = neg_res ? (64'd0 - prod) : prod;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULT) begin
                        state_nxt = S_MULT;
                    end else if (b == 32'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MULT: begin
                busy = 1'b1;
                if (last_iter) state_nxt = S_FIX;
            end
            S_DIV: begin
                busy = 1'b1;
                if (last_iter) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                div_zero  = dz_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            op_q    <= 1'b0;
            neg_res <= 1'b0;
            neg_a   <= 1'b0;
            dz_q    <= 1'b0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_res <= a_neg ^ b_neg;
                        neg_a   <= a_neg;
                        dz_q    <= (op == OP_DIV) && (b == 32'd0);
                        cnt     <= '0;
                        prod    <= '0;
                        mcand   <= {31'd0, a_mag};
                        mplier  <= b_mag;
                        rem     <= '0;
                        quo     <= a_mag[31:0];
                        dvsr    <= b_mag;
                    end
                end
                S_MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                end
                S_DIV: begin
                    rem <= fits ? rem_sub : rem_sh[31:0];
                    quo <= {quo[30:0], fits};
                    cnt <= cnt + 6'd1;
                end
                S_FIX: begin
                    if (op_q == OP_MULT) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else begin
                        lo <= neg_res ? (32'd0 - quo) : quo;
                        hi <= neg_a ? (32'd0 - rem) : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
